// File: rtl/timer_run_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// timer_run_ctrl_pkg
//   Shared definitions for the MM:SS timer run/stop/load sequencer:
//   FSM state encodings (3-bit, visible on the debug LEDs) and the
//   seven-segment display mode codes.
// ----------------------------------------------------------------------------
package timer_run_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CHECK = 3'd2,
      ST_RUN   = 3'd3,
      ST_PAUSE = 3'd4,
      ST_ALARM = 3'd5,
      ST_ERROR = 3'd6
   } state_t;

   localparam logic [1:0] DISP_DIGITS = 2'd0;  // plain MM:SS digits
   localparam logic [1:0] DISP_BLINK  = 2'd1;  // blinking digits (paused)
   localparam logic [1:0] DISP_DONE   = 2'd2;  // "donE" text
   localparam logic [1:0] DISP_ERR    = 2'd3;  // "Err" text

endpackage

// File: rtl/timer_run_ctrl_button_sync.sv
// ----------------------------------------------------------------------------
// timer_run_ctrl_button_sync
//   Turns one raw, bouncing push-button into a single-cycle command pulse.
//   Chain: 2-flop synchroniser -> stable-for-DEBOUNCE_CYC filter -> rising
//   edge detect. The pulse appears on the clock edge where the filtered level
//   rises; a held button therefore gives exactly one pulse.
// Ports
//   i_clk        system clock, rising edge
//   i_reset      asynchronous, active-high
//   i_btn_raw    raw asynchronous button level
//   o_cmd_pulse  one-clk command pulse (registered)
// ----------------------------------------------------------------------------
module timer_run_ctrl_button_sync
   import timer_run_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_btn_raw,
   output logic o_cmd_pulse
);

   localparam int              CW       = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYC - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_stable;
   logic [CW-1:0] r_cnt;
   logic          r_cmd;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
         r_cmd    <= 1'b0;
      end else begin
         r_sync1 <= i_btn_raw;
         r_sync2 <= r_sync1;
         r_cmd   <= 1'b0;
         if (r_sync2 == r_stable) begin
            // Any bounce back to the filtered level restarts the stability window.
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            // Level differed for DEBOUNCE_CYC consecutive cycles: accept it.
            // The counter stops here, so it can never run past CNT_LAST.
            r_stable <= r_sync2;
            r_cnt    <= '0;
            r_cmd    <= r_sync2;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_cmd_pulse = r_cmd;

endmodule

// File: rtl/timer_run_ctrl.sv
// ----------------------------------------------------------------------------
// timer_run_ctrl
//   Run/stop/load sequencer for the MM:SS down-count timer datapath.
//   Debounces three buttons into commands, drives the datapath load strobe and
//   the tick-gated count enable, runs the alarm and error-hold phases, and
//   selects the seven-segment display mode.
// Ports
//   i_clk, i_reset              clock / async active-high reset
//   i_btn_start/stop/load       raw push-buttons
//   i_tick_1hz                  one-clk pulse per second
//   i_cnt_done                  datapath at 00:00 (level)
//   i_cnt_err                   preset invalid (level, valid 1 clk after load)
//   o_load                      one-clk preset capture strobe (Moore)
//   o_ce                        count enable = RUN & tick (combinational)
//   o_alarm                     alarm LED, toggles per tick in ALARM
//   o_err_led                   high in ERROR
//   o_disp_mode                 display mode code
//   o_state                     current FSM state for debug LEDs
// ----------------------------------------------------------------------------
module timer_run_ctrl
   import timer_run_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int ALARM_SECS   = 10
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_btn_start,
   input  logic       i_btn_stop,
   input  logic       i_btn_load,
   input  logic       i_tick_1hz,
   input  logic       i_cnt_done,
   input  logic       i_cnt_err,
   output logic       o_load,
   output logic       o_ce,
   output logic       o_alarm,
   output logic       o_err_led,
   output logic [1:0] o_disp_mode,
   output logic [2:0] o_state
);

   localparam int             ACW        = $clog2(ALARM_SECS + 1);
   localparam logic [ACW-1:0] ALARM_LAST = ACW'(ALARM_SECS - 1);

   // Button index order: 0 start, 1 stop, 2 load.
   logic [2:0] w_btn_raw;
   logic [2:0] w_cmd;
   logic       w_start_cmd;
   logic       w_stop_cmd;
   logic       w_load_cmd;
   logic       w_any_cmd;

   state_t         r_state;
   state_t         w_state_next;
   logic           r_alarm;
   logic [ACW-1:0] r_alarm_cnt;

   assign w_btn_raw = {i_btn_load, i_btn_stop, i_btn_start};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_btn
         timer_run_ctrl_button_sync #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
         ) u_btn (
            .i_clk       (i_clk),
            .i_reset     (i_reset),
            .i_btn_raw   (w_btn_raw[gi]),
            .o_cmd_pulse (w_cmd[gi])
         );
      end
   endgenerate

   // Same-cycle commands: load beats stop beats start; losers are dropped.
   assign w_load_cmd  = w_cmd[2];
   assign w_stop_cmd  = w_cmd[1] & ~w_cmd[2];
   assign w_start_cmd = w_cmd[0] & ~w_cmd[1] & ~w_cmd[2];
   assign w_any_cmd   = |w_cmd;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_load_cmd)                      w_state_next = ST_LOAD;
            else if (w_start_cmd && !i_cnt_done) w_state_next = ST_RUN;
         end
         ST_LOAD:  w_state_next = ST_CHECK;
         ST_CHECK: w_state_next = i_cnt_err ? ST_ERROR : ST_IDLE;
         ST_RUN: begin
            // Reaching 00:00 wins over any command arriving the same cycle.
            if (i_cnt_done)      w_state_next = ST_ALARM;
            else if (w_load_cmd) w_state_next = ST_LOAD;
            else if (w_stop_cmd) w_state_next = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (w_load_cmd)       w_state_next = ST_LOAD;
            else if (w_start_cmd) w_state_next = ST_RUN;
         end
         ST_ALARM: begin
            // The tick that would bring the counter to ALARM_SECS ends the phase.
            if (w_any_cmd)                                   w_state_next = ST_IDLE;
            else if (i_tick_1hz && r_alarm_cnt == ALARM_LAST) w_state_next = ST_IDLE;
         end
         ST_ERROR: begin
            if (w_load_cmd) w_state_next = ST_LOAD;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Alarm blink flop and tick counter, both live only while in ALARM.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_alarm     <= 1'b0;
         r_alarm_cnt <= '0;
      end else if (r_state != ST_ALARM && w_state_next == ST_ALARM) begin
         r_alarm     <= 1'b1;
         r_alarm_cnt <= '0;
      end else if (r_state == ST_ALARM && w_state_next != ST_ALARM) begin
         r_alarm     <= 1'b0;
         r_alarm_cnt <= '0;
      end else if (r_state == ST_ALARM && i_tick_1hz) begin
         r_alarm     <= ~r_alarm;
         r_alarm_cnt <= r_alarm_cnt + ACW'(1);
      end
   end

   // Moore decode straight from the state register.
   always_comb begin
      o_load      = 1'b0;
      o_err_led   = 1'b0;
      o_disp_mode = DISP_DIGITS;
      case (r_state)
         ST_LOAD:  o_load = 1'b1;
         ST_PAUSE: o_disp_mode = DISP_BLINK;
         ST_ALARM: o_disp_mode = DISP_DONE;
         ST_ERROR: begin
            o_err_led   = 1'b1;
            o_disp_mode = DISP_ERR;
         end
         default: ;
      endcase
   end

   // Zero-latency enable: a tick in the last RUN cycle still counts.
   assign o_ce    = (r_state == ST_RUN) & i_tick_1hz;
   assign o_alarm = r_alarm;
   assign o_state = r_state;

endmodule

// File: tb/tb_timer_run_ctrl.sv
module tb_timer_run_ctrl;

   logic       i_clk = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_btn_start = 1'b0;
   logic       i_btn_stop = 1'b0;
   logic       i_btn_load = 1'b0;
   logic       i_tick_1hz = 1'b0;
   logic       i_cnt_done = 1'b0;
   logic       i_cnt_err = 1'b0;
   logic       o_load;
   logic       o_ce;
   logic       o_alarm;
   logic       o_err_led;
   logic [1:0] o_disp_mode;
   logic [2:0] o_state;

   int n_pass  = 0;
   int n_total = 0;

   timer_run_ctrl #(
      .DEBOUNCE_CYC (4),
      .ALARM_SECS   (3)
   ) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_btn_start (i_btn_start),
      .i_btn_stop  (i_btn_stop),
      .i_btn_load  (i_btn_load),
      .i_tick_1hz  (i_tick_1hz),
      .i_cnt_done  (i_cnt_done),
      .i_cnt_err   (i_cnt_err),
      .o_load      (o_load),
      .o_ce        (o_ce),
      .o_alarm     (o_alarm),
      .o_err_led   (o_err_led),
      .o_disp_mode (o_disp_mode),
      .o_state     (o_state)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   // mask = {load, stop, start}; hold for 7 clks so the FSM has acted, then release.
   task automatic press(input logic [2:0] mask);
      i_btn_load  = mask[2];
      i_btn_stop  = mask[1];
      i_btn_start = mask[0];
      step(7);
      i_btn_load  = 1'b0;
      i_btn_stop  = 1'b0;
      i_btn_start = 1'b0;
      $display("press %b -> state %0d", mask, o_state);
   endtask

   task automatic test_reset();
      i_reset    = 1'b1;
      i_tick_1hz = 1'b1;
      step(2);
      n_total++; if (o_state !== 3'd0) $display("FAIL reset_state: got %0d want 0", o_state); else n_pass++;
      n_total++; if ({o_load, o_ce, o_alarm, o_err_led} !== 4'b0000)
         $display("FAIL reset_outs: got %b want 0000", {o_load, o_ce, o_alarm, o_err_led}); else n_pass++;
      n_total++; if (o_disp_mode !== 2'd0) $display("FAIL reset_disp: got %0d want 0", o_disp_mode); else n_pass++;
      i_tick_1hz = 1'b0;
      i_reset    = 1'b0;
      step(2);
      $display("reset released, state %0d", o_state);
   endtask

   task automatic test_load_ok();
      int         first = -1;
      int         pulses = 0;
      logic [2:0] st [1:10];
      i_cnt_err  = 1'b0;
      i_btn_load = 1'b1;          // held across all 10 clks: must still give one pulse
      for (int i = 1; i <= 10; i++) begin
         step(1);
         st[i] = o_state;
         if (o_load) begin
            pulses++;
            if (first < 0) first = i;
         end
      end
      i_btn_load = 1'b0;
      n_total++; if (first !== 7) $display("FAIL load_latency: got %0d want 7", first); else n_pass++;
      n_total++; if (pulses !== 1) $display("FAIL load_pulses: got %0d want 1", pulses); else n_pass++;
      n_total++; if ({st[7], st[8], st[9]} !== {3'd1, 3'd2, 3'd0})
         $display("FAIL load_seq: got %0d,%0d,%0d want 1,2,0", st[7], st[8], st[9]); else n_pass++;
      $display("load ok: first pulse clk %0d, %0d pulse(s)", first, pulses);
      step(8);
   endtask

   task automatic test_error();
      i_cnt_err = 1'b1;
      press(3'b100);
      step(2);
      n_total++; if (o_state !== 3'd6) $display("FAIL err_state: got %0d want 6", o_state); else n_pass++;
      n_total++; if (o_err_led !== 1'b1 || o_disp_mode !== 2'd3)
         $display("FAIL err_outs: got led=%b disp=%0d want led=1 disp=3", o_err_led, o_disp_mode); else n_pass++;
      step(8);
      press(3'b001);
      n_total++; if (o_state !== 3'd6) $display("FAIL err_start_ignored: got %0d want 6", o_state); else n_pass++;
      step(8);
      i_cnt_err = 1'b0;
      press(3'b100);
      n_total++; if (o_state !== 3'd1 || o_load !== 1'b1)
         $display("FAIL err_retry_load: got state=%0d load=%b want 1/1", o_state, o_load); else n_pass++;
      step(2);
      n_total++; if (o_state !== 3'd0 || o_err_led !== 1'b0)
         $display("FAIL err_cleared: got state=%0d led=%b want 0/0", o_state, o_err_led); else n_pass++;
      step(8);
   endtask

   task automatic test_run_pause();
      int ce_hits = 0;
      int ce_bad  = 0;
      i_cnt_done = 1'b0;
      press(3'b001);
      n_total++; if (o_state !== 3'd3) $display("FAIL run_enter: got %0d want 3", o_state); else n_pass++;
      for (int i = 0; i < 5; i++) begin
         i_tick_1hz = 1'b1;
         #1;
         if (o_ce) ce_hits++;
         step(1);
         i_tick_1hz = 1'b0;
         #1;
         if (o_ce) ce_bad++;
         step(1);
      end
      n_total++; if (ce_hits !== 5 || ce_bad !== 0)
         $display("FAIL run_ce_count: got %0d pulses %0d stray want 5/0", ce_hits, ce_bad); else n_pass++;
      $display("run: %0d ce pulses from 5 ticks", ce_hits);
      // Stop with a tick landing in the last RUN cycle.
      i_btn_stop = 1'b1;
      step(6);
      i_tick_1hz = 1'b1;
      #1;
      n_total++; if (o_ce !== 1'b1 || o_state !== 3'd3)
         $display("FAIL ce_on_stop_edge: got ce=%b state=%0d want 1/3", o_ce, o_state); else n_pass++;
      step(1);
      i_tick_1hz = 1'b0;
      i_btn_stop = 1'b0;
      n_total++; if (o_state !== 3'd4 || o_disp_mode !== 2'd1)
         $display("FAIL pause_enter: got state=%0d disp=%0d want 4/1", o_state, o_disp_mode); else n_pass++;
      i_tick_1hz = 1'b1;
      #1;
      n_total++; if (o_ce !== 1'b0) $display("FAIL pause_ce: got %b want 0", o_ce); else n_pass++;
      step(1);
      i_tick_1hz = 1'b0;
      step(8);
      press(3'b001);
      n_total++; if (o_state !== 3'd3) $display("FAIL resume: got %0d want 3", o_state); else n_pass++;
      step(8);
   endtask

   task automatic test_alarm();
      logic [2:0] exp_alarm;
      logic [8:0] exp_state;
      exp_alarm = 3'b010;                      // alarm after ticks 1,2,3
      exp_state = {3'd5, 3'd5, 3'd0};          // state after ticks 1,2,3
      i_btn_stop = 1'b1;
      step(6);
      i_cnt_done = 1'b1;                       // done rises with the stop command
      step(1);
      i_btn_stop = 1'b0;
      n_total++; if (o_state !== 3'd5 || o_alarm !== 1'b1 || o_disp_mode !== 2'd2)
         $display("FAIL alarm_enter: got state=%0d alarm=%b disp=%0d want 5/1/2", o_state, o_alarm, o_disp_mode); else n_pass++;
      for (int t = 0; t < 3; t++) begin
         i_tick_1hz = 1'b1;
         #1;
         n_total++; if (o_ce !== 1'b0) $display("FAIL alarm_ce tick%0d: got %b want 0", t + 1, o_ce); else n_pass++;
         step(1);
         i_tick_1hz = 1'b0;
         n_total++; if (o_alarm !== exp_alarm[2 - t] || o_state !== exp_state[8 - 3*t -: 3])
            $display("FAIL alarm_tick%0d: got alarm=%b state=%0d want %b/%0d", t + 1, o_alarm, o_state,
                     exp_alarm[2 - t], exp_state[8 - 3*t -: 3]); else n_pass++;
         $display("alarm tick %0d: alarm=%b state=%0d", t + 1, o_alarm, o_state);
         step(1);
      end
      i_cnt_done = 1'b0;
      step(8);
   endtask

   task automatic test_bounce();
      int moved = 0;
      i_btn_start = 1'b1;
      step(2);
      i_btn_start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         if (o_state !== 3'd0) moved++;
      end
      n_total++; if (moved !== 0) $display("FAIL glitch_filtered: state left IDLE %0d times want 0", moved); else n_pass++;
      press(3'b101);
      n_total++; if (o_state !== 3'd1) $display("FAIL load_beats_start: got %0d want 1", o_state); else n_pass++;
      step(2);
      n_total++; if (o_state !== 3'd0) $display("FAIL load_beats_start_idle: got %0d want 0", o_state); else n_pass++;
      step(8);
   endtask

   task automatic test_reset_in_alarm();
      i_cnt_done = 1'b0;
      press(3'b001);
      i_cnt_done = 1'b1;
      step(1);
      for (int t = 0; t < 2; t++) begin
         i_tick_1hz = 1'b1;
         step(1);
         i_tick_1hz = 1'b0;
         step(1);
      end
      n_total++; if (o_state !== 3'd5 || o_alarm !== 1'b1)
         $display("FAIL mid_blink: got state=%0d alarm=%b want 5/1", o_state, o_alarm); else n_pass++;
      i_tick_1hz = 1'b1;
      i_reset    = 1'b1;
      #1;
      n_total++; if (o_state !== 3'd0 || o_alarm !== 1'b0 || o_ce !== 1'b0)
         $display("FAIL async_reset: got state=%0d alarm=%b ce=%b want 0/0/0", o_state, o_alarm, o_ce); else n_pass++;
      step(1);
      i_tick_1hz = 1'b0;
      i_reset    = 1'b0;
      step(1);
      press(3'b001);                           // cnt_done still high
      n_total++; if (o_state !== 3'd0) $display("FAIL start_when_done: got %0d want 0", o_state); else n_pass++;
      step(2);
      n_total++; if (o_state !== 3'd0) $display("FAIL start_when_done_hold: got %0d want 0", o_state); else n_pass++;
      i_cnt_done = 1'b0;
      step(8);
   endtask

   initial begin
      test_reset();
      test_load_ok();
      test_error();
      test_run_pause();
      test_alarm();
      test_bounce();
      test_reset_in_alarm();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
